// File: rtl/prefetch_pkg.sv
// Shared types and sizing for the instruction prefetch unit and its byte queue.
package prefetch_pkg;

    localparam int PC_W      = 16;
    localparam int BYTE_W    = 8;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_e;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/prefetch_ctrl_byte_fifo.sv
// Byte queue between prefetch and decode: circular storage with push, pull and
// a synchronous flush that empties it in one cycle.
module byte_fifo
    import prefetch_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    localparam int CNT_W = cnt_w(DEPTH),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pull,
    output logic [BYTE_W-1:0] head_data,
    output logic              valid,
    output logic [CNT_W-1:0]  count
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              do_push;
    logic              do_pull;

    always_comb begin
        do_push = push && !flush && (cnt_q != FULL);
        do_pull = pull && !flush && (cnt_q != '0);
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pull) rd_d = rd_q + 1'b1;
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pull);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible through cnt_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

    assign valid     = (cnt_q != '0);
    assign head_data = valid ? mem_q[rd_q] : '0;
    assign count     = cnt_q;

endmodule

// File: rtl/prefetch_ctrl.sv
// Instruction prefetch: sequential single-byte reads into the byte queue, with
// branch redirect that flushes the queue and drops any read still on the bus.
module prefetch_ctrl
    import prefetch_pkg::*;
#(
    parameter int              DEPTH    = DEF_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    localparam int             CNT_W    = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              mem_req,
    output logic [PC_W-1:0]   mem_addr,
    input  logic              mem_ack,
    input  logic [BYTE_W-1:0] mem_data,
    output logic              q_valid,
    output logic [BYTE_W-1:0] q_data,
    output logic [PC_W-1:0]   q_pc,
    input  logic              q_pull,
    output logic [CNT_W-1:0]  q_count
);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   FULL_EXT = (CNT_W + 1)'(DEPTH);

    state_e          state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] mem_addr_q, mem_addr_d;
    logic [PC_W-1:0] q_pc_q, q_pc_d;
    logic            mem_req_q, mem_req_d;
    logic            push;
    logic            pull_eff;
    logic [CNT_W:0]  cnt_after;
    logic            room_after;

    // Bus handshake: mem_req/mem_addr are held unchanged until the cycle
    // mem_ack is high; that edge completes the read and mem_data is taken.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        push       = 1'b0;
        pull_eff   = q_pull && q_valid && !redirect_valid;
        cnt_after  = {1'b0, q_count} + (CNT_W + 1)'(1) - (CNT_W + 1)'(pull_eff);
        room_after = (cnt_after < FULL_EXT);
        q_pc_d     = q_pc_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            q_pc_d     = redirect_pc;
        end else if (pull_eff) begin
            q_pc_d = q_pc_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                mem_req_d  = 1'b0;
                mem_addr_d = fetch_pc_q;
                if (!redirect_valid && (q_count < FULL)) state_d = REQ;
            end
            REQ: begin
                if (!mem_req_q) begin
                    // First cycle in REQ: launch the read unless redirected.
                    mem_addr_d = fetch_pc_q;
                    if (redirect_valid) state_d = IDLE;
                    else mem_req_d = 1'b1;
                end else if (redirect_valid) begin
                    if (mem_ack) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end else begin
                        state_d = DROP;
                    end
                end else if (mem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 1'b1;
                    mem_addr_d = fetch_pc_q + 1'b1;
                    if (!room_after) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end
            DROP: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            q_pc_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            q_pc_q     <= q_pc_d;
        end
    end

    // The queue always holds a contiguous address run, so the head address
    // is tracked arithmetically rather than stored per entry.
    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (mem_data),
        .pull      (pull_eff),
        .head_data (q_data),
        .valid     (q_valid),
        .count     (q_count)
    );

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign q_pc     = q_pc_q;

endmodule
